// File: rtl/nvram_pkg.sv
// Shared types and constants for the NVRAM / high-score upload path.
package nvram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAUSE = 2'd1,
    READY = 2'd2,
    FETCH = 2'd3
  } nv_state_t;

  // Byte returned for any address outside the RAM image.
  localparam logic [7:0] NV_FILL = 8'hFF;

endpackage

// File: rtl/nvram_upload.sv
// Streams game work RAM back to the HPS over the hps_io ioctl upload channel.
// Optional: define NVRAM_UPLOAD_CHECKSUM_EN to append a zero-sum checksum byte at address SIZE.
module nvram_upload
  import nvram_pkg::*;
#(
  parameter int INDEX   = 4,
  parameter int AW      = 11,
  parameter int SIZE    = 2048,
  parameter int RAM_LAT = 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          cpu_pause_req,
  input  logic          cpu_paused,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  output logic          upload_done
);

  localparam logic [7:0]  IDX    = 8'(INDEX);
  localparam logic [24:0] SIZE_A = 25'(SIZE);
  localparam logic [1:0]  LAT    = 2'(RAM_LAT);

  nv_state_t   state;
  logic        session;
  logic        session_q;
  logic [1:0]  lat_cnt;
  logic        oor;
  logic [7:0]  fill;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign session = ioctl_upload && (ioctl_index == IDX);

  // NOTE: all state and outputs are registers updated with <= so every
  // branch below sees the pre-edge values, whatever the statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      session_q     <= 1'b0;
      lat_cnt       <= 2'd0;
      oor           <= 1'b0;
      fill          <= 8'h00;
      ioctl_din     <= 8'h00;
      ioctl_wait    <= 1'b0;
      cpu_pause_req <= 1'b0;
      ram_addr      <= '0;
      ram_rd        <= 1'b0;
      upload_done   <= 1'b0;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
      csum          <= 8'h00;
`endif
    end else begin
      session_q   <= session;
      ram_rd      <= 1'b0;
      upload_done <= 1'b0;

      // Losing the upload strobe ends the session from any state; a read
      // still in flight is simply abandoned.
      if (state != IDLE && !ioctl_upload) begin
        state         <= IDLE;
        cpu_pause_req <= 1'b0;
        ioctl_wait    <= 1'b0;
        upload_done   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (session && !session_q) begin
              state         <= PAUSE;
              cpu_pause_req <= 1'b1;
              ioctl_wait    <= 1'b1;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
              csum          <= 8'h00;
`endif
            end
          end

          PAUSE: begin
            if (cpu_paused) begin
              state      <= READY;
              ioctl_wait <= 1'b0;
            end
          end

          READY: begin
            if (ioctl_rd) begin
              state      <= FETCH;
              ioctl_wait <= 1'b1;
              lat_cnt    <= 2'd0;
              if (ioctl_addr < SIZE_A) begin
                oor      <= 1'b0;
                ram_addr <= ioctl_addr[AW-1:0];
                ram_rd   <= 1'b1;
              end else begin
                oor <= 1'b1;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
                fill <= (ioctl_addr == SIZE_A) ? (~csum + 8'd1) : NV_FILL;
`else
                fill <= NV_FILL;
`endif
              end
            end
          end

          FETCH: begin
            if (oor) begin
              ioctl_din  <= fill;
              ioctl_wait <= 1'b0;
              state      <= READY;
            end else if (lat_cnt == LAT) begin
              ioctl_din  <= ram_q;
              ioctl_wait <= 1'b0;
              state      <= READY;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
              csum       <= csum + ram_q;
`endif
            end else begin
              lat_cnt <= lat_cnt + 2'd1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/nvram_upload.md
# nvram_upload

Reads game work RAM back to the HPS through the `hps_io` ioctl upload channel so high-score and NVRAM contents can be saved; it is the upload-direction counterpart of the ROM download path. It sits in the `emu` top level beside `hps_io`. It pauses the main CPU before touching RAM, and holds `ioctl_wait` until each byte is ready.

## Interface

Parameters:
- `INDEX`, default 4: `ioctl_index` value that selects this block.
- `AW`, default 11: RAM address width.
- `SIZE`, default 2048: number of bytes uploaded.
- `RAM_LAT`, default 1: RAM read latency in cycles; legal values are 1 and 2.

Ports (all synchronous to `clk_sys`):
- `clk_sys` in 1: system clock, 36.864 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_upload` in 1: upload session active, from `hps_io`.
- `ioctl_index` in 8: selected file index.
- `ioctl_rd` in 1: one-cycle byte read strobe.
- `ioctl_addr` in 25: byte address of the read.
- `ioctl_din` out 8: byte returned to `hps_io`.
- `ioctl_wait` out 1: stall `hps_io` while high.
- `cpu_pause_req` out 1: request that the main CPU halt.
- `cpu_paused` in 1: CPU is halted and off the RAM bus.
- `ram_addr` out AW: RAM read address.
- `ram_rd` out 1: RAM read enable, one cycle.
- `ram_q` in 8: RAM read data.
- `upload_done` out 1: one-cycle pulse at session end.

## Operation

- A session is active when `ioctl_upload` is high and `ioctl_index == INDEX`. Any other index is ignored; all outputs keep their idle values.
- State machine:
  - IDLE → PAUSE on the rising edge of an active session. Entering PAUSE sets `cpu_pause_req` and `ioctl_wait` to 1.
  - PAUSE → READY when `cpu_paused` is sampled high. Entering READY clears `ioctl_wait`.
  - READY → FETCH on `ioctl_rd`. Entering FETCH:
    - sets `ioctl_wait` to 1;
    - drives `ram_addr = ioctl_addr[AW-1:0]`;
    - pulses `ram_rd`.
  - FETCH counts `RAM_LAT` cycles, then captures `ram_q` into `ioctl_din`, clears `ioctl_wait`, and returns to READY.
  - Any state → IDLE when `ioctl_upload` falls. On that transition, clear `cpu_pause_req` and `ioctl_wait`, and pulse `upload_done`.
- Out-of-range address (`ioctl_addr >= SIZE`): no RAM access and no `ram_rd`. `ioctl_din` is 8'hFF, and the block still spends one FETCH cycle.
- `ioctl_rd` outside READY is dropped. This cannot occur legally because `ioctl_wait` is high in those states.
- `ioctl_upload` falling in PAUSE or FETCH is an abort:
  - go to IDLE immediately;
  - discard any in-flight `ram_q`;
  - `upload_done` still pulses.
- `cpu_paused` falling during READY or FETCH is tolerated and not re-checked.
- Reset values: all outputs 0 (`ioctl_din` = 8'h00); state IDLE.
- Asserting `reset_n` mid-session returns everything to reset values at once. The CPU is released.

## Timing

- `ioctl_rd` at cycle t:
  - `ram_rd` and `ram_addr` valid at t+1;
  - `ioctl_wait` high from t+1;
  - `ioctl_din` valid and `ioctl_wait` low at t+1+RAM_LAT+1.
- Per-byte latency is RAM_LAT+2 cycles.
- Pause: `ioctl_wait` and `cpu_pause_req` rise one cycle after the session is detected. `ioctl_wait` falls one cycle after `cpu_paused` is sampled high.
- Abort: `cpu_pause_req` and `ioctl_wait` are low, and `upload_done` is high, on the cycle after `ioctl_upload` is sampled low.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- `NVRAM_UPLOAD_CHECKSUM_EN` defined:
  - a running 8-bit sum of every byte returned is kept; it clears at session start;
  - a read at address SIZE returns the two's-complement of that sum, so the full file sums to zero;
  - addresses above SIZE return 8'hFF.
- Undefined: address SIZE returns 8'hFF like any other out-of-range address; no accumulator is built.

## Structure

- Shared package `nvram_pkg`:
  - state enum `nv_state_t` (IDLE, PAUSE, READY, FETCH);
  - constant `NV_FILL = 8'hFF`.
- Single flat module; there is no natural sub-module. The latency counter and the checksum accumulator stay inline.

## Test plan

- Basic read: index 4, upload high, `cpu_paused` after 5 cycles, then read address 0x010 with `ram_q`=8'hA5. Expect `cpu_pause_req` high, `ioctl_wait` falling after pause, `ram_addr`=0x010, `ioctl_din`=8'hA5 three cycles after `ioctl_rd` (RAM_LAT=1).
- Wrong index: index 3 with a full read sequence → `cpu_pause_req`, `ram_rd` and `ioctl_wait` stay 0.
- Out of range: read at address 2050 → no `ram_rd`, `ioctl_din`=8'hFF, `ioctl_wait` low after 2 cycles.
- Abort: drop `ioctl_upload` during FETCH → next cycle `cpu_pause_req`=0, `ioctl_wait`=0, one `upload_done` pulse, `ioctl_din` unchanged.
- Reset: assert `reset_n` low in READY → all outputs 0 asynchronously; after release, a new session re-pauses the CPU.
- Checksum (`NVRAM_UPLOAD_CHECKSUM_EN`): bytes 01, 02, FD, then a read at address SIZE → 8'h00; with the macro undefined → 8'hFF.
